bram_port_master: RTL and testbench
===================================

BRAM_PORT_MASTER -- requirements
Module: bram_port_master

Interface
REQ-001 Parameter ADDR_W, default 10: BRAM address width in bits.
REQ-002 Parameter DATA_W, default 16: BRAM word width (8-bit real + 8-bit imaginary).
REQ-003 Parameter READ_LAT, default 2: BRAM read latency in cycles (1 or 2).
REQ-004 Parameter FIFO_DEPTH = READ_LAT+2 (derived, not overridable): response buffer entries.
REQ-005 clk_i  in  1  single clock; the block and the attached BRAM port both run on it.
REQ-006 rst_ni  in  1  reset, synchronous, active-low.
REQ-007 req_valid_i  in  1  request valid.
REQ-008 req_ready_o  out  1  request accepted when valid and ready are both high.
REQ-009 req_we_i  in  1  1 = write, 0 = read.
REQ-010 req_addr_i  in  ADDR_W  word address.
REQ-011 req_wdata_i  in  DATA_W  write data.
REQ-012 rsp_valid_o  out  1  read data valid.
REQ-013 rsp_rdata_o  out  DATA_W  read data.
REQ-014 rsp_ready_i  in  1  consumer accepts the response.
REQ-015 bram_m  bram_intrf.master  -  drives we/addr/din and samples dout of one port of system_memory.

Function
REQ-016 fire = req_valid_i & req_ready_o; bram_m.addr = req_addr_i, bram_m.din = req_wdata_i, bram_m.we = fire & req_we_i, all combinational.
REQ-017 A write completes on its fire cycle and produces no response.
REQ-018 A read firing in cycle T enters a READ_LAT-deep in-flight valid shift register; in cycle T+READ_LAT, bram_m.dout is pushed into the response FIFO.
REQ-019 rsp_valid_o is high whenever the FIFO is non-empty; rsp_rdata_o is the FIFO head; pop on rsp_valid_o & rsp_ready_i.
REQ-020 Minimum read latency: rsp_valid_o asserts in cycle T+READ_LAT+1.
REQ-021 Responses are returned in request order, with no loss or duplication.
REQ-022 used = in-flight reads + FIFO occupancy, held in a register; req_ready_o = (used < FIFO_DEPTH), derived from the registered value only; no combinational path from req_* or rsp_ready_i.
REQ-023 A read fire increments used; a pop decrements it; both in the same cycle leave used unchanged; writes never change used.
REQ-024 A simultaneous push and pop on the FIFO is legal and leaves occupancy unchanged; FIFO overflow is impossible by REQ-022, and the FIFO never underflows.
REQ-025 With rsp_ready_i held high, sustained throughput is one read per cycle (req_ready_o never drops).
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 rsp_valid_o, once asserted, holds with stable data until popped.

Reset
REQ-028 While rst_ni is low at a clock edge: FIFO empty, in-flight register cleared, used = 0, rsp_valid_o = 0, req_ready_o = 0, bram_m.we = 0.
REQ-029 req_ready_o rises in the first cycle after rst_ni returns high.
REQ-030 Reset mid-operation discards in-flight and buffered reads, with no response after release; BRAM contents are untouched.

Configuration
REQ-031 Macro BRAM_PORT_MASTER_STATS_EN defined: adds outputs wr_count_o and rd_count_o (32 bits each) counting write fires and read fires; they saturate at 0xFFFFFFFF and reset to 0.
REQ-032 Macro not defined: these ports and counters are absent; all other behaviour is identical.

Verification (READ_LAT=2, FIFO_DEPTH=4)
REQ-033 Write addr 0x005 data 0x1234 in cycle T, read addr 0x005 in cycle T+1 -> rsp_valid_o in cycle T+4 with rsp_rdata_o = 0x1234.
REQ-034 Preload addr 0..7 = 0x0100+addr; issue back-to-back reads 0..7 with rsp_ready_i = 1 -> req_ready_o stays 1; eight responses 0x0100..0x0107 in consecutive cycles.
REQ-035 rsp_ready_i = 0 with continuous read requests -> exactly 4 accepted, then req_ready_o = 0; raise rsp_ready_i -> 4 in-order responses, and req_ready_o returns to 1 the cycle after the first pop.
REQ-036 Interleave write-read-write-read to addrs 3 and 4 (0xAAAA, 0x5555) -> responses 0xAAAA then 0x5555, with no response generated for the writes.
REQ-037 Assert rst_ni low for 1 cycle with 2 reads in flight and 1 buffered response -> rsp_valid_o = 0 thereafter until a new read; req_ready_o = 1 one cycle after release.
REQ-038 With BRAM_PORT_MASTER_STATS_EN defined: 3 writes and 5 reads -> wr_count_o = 3, rd_count_o = 5; force a counter to 0xFFFFFFFF and fire once more -> the counter stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/bram_port_master_if.sv
// bram_intrf: one port of a single-clock BRAM (system_memory).
//   we   : write enable, driven by the master
//   addr : word address, driven by the master
//   din  : write data, driven by the master
//   dout : read data, driven by the memory; valid READ_LAT cycles after addr is sampled
interface bram_intrf #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) ();
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output we, output addr, output din, input dout);
    modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/bram_port_master.sv
// bram_port_master: valid/ready request front-end for one BRAM port.
// Writes complete on their accept cycle with no response; reads are tracked
// through a READ_LAT-deep in-flight pipe and their data is buffered in a
// small response FIFO so the consumer may stall without losing data.
// Credit accounting (in-flight + buffered) guarantees the FIFO never overflows.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   req_valid_i/ready_o request handshake; req_we_i, req_addr_i, req_wdata_i payload
//   rsp_valid_o/ready_i response handshake; rsp_rdata_o read data (FIFO head)
//   bram_m             master side of the BRAM port (we/addr/din out, dout in)
//   wr_count_o, rd_count_o  saturating fire counters, only with
//                      BRAM_PORT_MASTER_STATS_EN defined
module bram_port_master #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    input  logic              rsp_ready_i,
    bram_intrf.master         bram_m
`ifdef BRAM_PORT_MASTER_STATS_EN
    ,
    output logic [31:0]       wr_count_o,
    output logic [31:0]       rd_count_o
`endif
);

    localparam int unsigned FIFO_DEPTH = READ_LAT + 2;
    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic                fire;
    logic                rd_fire;
    logic                wr_fire;
    logic                push;
    logic                pop;

    logic [READ_LAT-1:0] inflight_q, inflight_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    used_q, used_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;

    // Pointer advance with wrap at FIFO_DEPTH (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request handshake; rst_ni gating keeps the BRAM write strobe low during reset
    assign fire    = req_valid_i & req_ready_o & rst_ni;
    assign rd_fire = fire & ~req_we_i;
    assign wr_fire = fire & req_we_i;

    assign bram_m.we   = wr_fire;
    assign bram_m.addr = req_addr_i;
    assign bram_m.din  = req_wdata_i;

    // Read data is on dout in the cycle the tracked read leaves the in-flight pipe
    assign push = inflight_q[READ_LAT-1];
    assign pop  = rsp_valid_q & rsp_ready_i;

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = fifo_mem_q[rd_ptr_q];

    // In-flight read tracking pipe
    always_comb begin
        inflight_d    = '0;
        inflight_d[0] = rd_fire;
        for (int i = 1; i < int'(READ_LAT); i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
    end

    // FIFO pointers, occupancy and credit count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        used_d   = used_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case ({rd_fire, pop})
            2'b10:   used_d = used_q + CNT_W'(1);
            2'b01:   used_d = used_q - CNT_W'(1);
            default: used_d = used_q;
        endcase

        // Registered so req_ready_o has no combinational path from req_* / rsp_ready_i
        ready_d     = (used_d < CNT_W'(FIFO_DEPTH));
        rsp_valid_d = (count_d != '0);
    end

    // Control state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            used_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            used_q      <= used_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Response data storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bram_m.dout;
        end
    end

`ifdef BRAM_PORT_MASTER_STATS_EN
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;

    // Saturating fire counters
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_fire && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (rd_fire && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_count_o = wr_cnt_q;
    assign rd_count_o = rd_cnt_q;
`endif

endmodule

// File: tb/tb_bram_port_master.sv
// Testbench for bram_port_master with READ_LAT=2 (FIFO depth 4).
// A behavioural BRAM sits on the port; a transaction-level model (memory
// array, timed pending-read queue, response queue) predicts every output.
module tb_bram_port_master;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = LAT + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_ready;
`ifdef BRAM_PORT_MASTER_STATS_EN
    logic [31:0]   wr_count;
    logic [31:0]   rd_count;
`endif

    always #5 clk = ~clk;

    bram_intrf #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    bram_port_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_ready_i (rsp_ready),
        .bram_m      (bif)
`ifdef BRAM_PORT_MASTER_STATS_EN
        ,
        .wr_count_o  (wr_count),
        .rd_count_o  (rd_count)
`endif
    );

    // Behavioural BRAM: read-first, two-stage output pipe
    logic [DW-1:0] bram_mem [1 << AW];
    logic [DW-1:0] br1, br2;
    always @(posedge clk) begin
        if (bif.we) bram_mem[bif.addr] <= bif.din;
        br1 <= bram_mem[bif.addr];
        br2 <= br1;
    end
    assign bif.dout = br2;

    // Reference model state
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] ref_mem [1 << AW];
    pend_t         pend[$];
    logic [DW-1:0] rspq[$];
    bit            ready_ok;
    int            cyc;
    logic [31:0]   m_wr, m_rd;
    int            n_err, n_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model
    task automatic step(input bit rstn, input bit v, input bit we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit rr, output bit acc);
        bit    exp_rdy;
        bit    fire;
        pend_t p;
        @(negedge clk);
        exp_rdy = ready_ok && ((pend.size() + rspq.size()) < DEPTH);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(rspq.size() != 0));
        if (rspq.size() != 0) check("rsp_rdata", 32'(rsp_rdata), 32'(rspq[0]));
`ifdef BRAM_PORT_MASTER_STATS_EN
        check("wr_count", wr_count, m_wr);
        check("rd_count", rd_count, m_rd);
`endif
        rst_n     = rstn;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        fire      = rstn && v && exp_rdy;
        acc       = v && req_ready;
        #1;
        check("bram_we", 32'(bif.we), 32'(fire && we));
        check("bram_addr", 32'(bif.addr), 32'(a));
        if (fire && we) check("bram_din", 32'(bif.din), 32'(d));
        @(posedge clk);
        if (!rstn) begin
            pend.delete();
            rspq.delete();
            ready_ok = 1'b0;
            m_wr     = '0;
            m_rd     = '0;
        end else begin
            if (rspq.size() != 0 && rr) void'(rspq.pop_front());
            while (pend.size() != 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                rspq.push_back(p.data);
            end
            if (fire && !we) begin
                p.due  = cyc + int'(LAT);
                p.data = ref_mem[a];
                pend.push_back(p);
                if (m_rd != 32'hFFFF_FFFF) m_rd++;
            end
            if (fire && we) begin
                ref_mem[a] = d;
                if (m_wr != 32'hFFFF_FFFF) m_wr++;
            end
            ready_ok = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, rr, acc);
    endtask

    initial begin
        bit acc;
        int acc_cnt;
        bit rstn, v, we, rr;

        for (int i = 0; i < (1 << AW); i++) begin
            bram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        n_err = 0; n_chk = 0; cyc = 0; ready_ok = 1'b0; m_wr = '0; m_rd = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        @(posedge clk);

        // Reset held, then release
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, acc);
        step(1'b0, 1'b1, 1'b1, 10'h001, 16'hDEAD, 1'b0, acc);
        idle(1, 1'b1);

        // Write then read of the same address
        step(1'b1, 1'b1, 1'b1, 10'h005, 16'h1234, 1'b1, acc);
        step(1'b1, 1'b1, 1'b0, 10'h005, '0, 1'b1, acc);
        idle(5, 1'b1);

        // Preload and back-to-back stream with consumer always ready
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, AW'(i), DW'(16'h0100 + i), 1'b1, acc);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, AW'(i), '0, 1'b1, acc);
            check("stream_ready", 32'(acc), 32'd1);
        end
        idle(6, 1'b1);

        // Consumer stalled: only FIFO_DEPTH reads accepted
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, AW'(i), '0, 1'b0, acc);
            if (acc) acc_cnt++;
        end
        check("stall_accepts", 32'(acc_cnt), 32'(DEPTH));
        idle(6, 1'b1);

        // Interleaved write/read
        step(1'b1, 1'b1, 1'b1, 10'h003, 16'hAAAA, 1'b1, acc);
        step(1'b1, 1'b1, 1'b0, 10'h003, '0, 1'b1, acc);
        step(1'b1, 1'b1, 1'b1, 10'h004, 16'h5555, 1'b1, acc);
        step(1'b1, 1'b1, 1'b0, 10'h004, '0, 1'b1, acc);
        idle(6, 1'b1);

        // Reset with two reads in flight and one buffered
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, AW'(i), '0, 1'b0, acc);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, acc);
        idle(6, 1'b1);

        // Randomized traffic over a small address window
        for (int i = 0; i < 800; i++) begin
            rstn = ($urandom_range(0, 99) != 0);
            v    = rstn && ($urandom_range(0, 9) < 7);
            we   = ($urandom_range(0, 9) < 3);
            rr   = ($urandom_range(0, 9) < 6);
            step(rstn, v, we, AW'($urandom_range(0, 15)), DW'($urandom), rr, acc);
        end
        idle(8, 1'b1);

`ifdef BRAM_PORT_MASTER_STATS_EN
        // Counter saturation
        @(negedge clk);
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        force dut.rd_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.wr_cnt_q;
        release dut.rd_cnt_q;
        m_wr = 32'hFFFF_FFFF;
        m_rd = 32'hFFFF_FFFF;
        step(1'b1, 1'b1, 1'b1, 10'h009, 16'h0F0F, 1'b1, acc);
        step(1'b1, 1'b1, 1'b0, 10'h009, '0, 1'b1, acc);
        idle(5, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
